// File: rtl/regfile_pkg.sv
// Shared constants and counter-update encoding for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC,
        CNT_CLR
    } cnt_op_e;

    // Clear dominates; a simultaneous issue and writeback cancel each other out.
    function automatic cnt_op_e cnt_sel(input logic inc, input logic dec, input logic clr);
        if (clr) return CNT_CLR;
        if (inc && !dec) return CNT_INC;
        if (dec && !inc) return CNT_DEC;
        return CNT_HOLD;
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one architectural register: up on issue, down on
// writeback, cleared by flush, with an underflow pulse for an unmatched writeback.
module sb_counter
    import regfile_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    cnt_op_e op;

    assign op        = cnt_sel(inc, dec, clr);
    assign underflow = (op == CNT_DEC) && (count == '0);

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the always blocks execute in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case (op)
                CNT_INC:  if (count != CNT_MAX) count <= count + 1'b1;
                CNT_DEC:  if (count != '0)      count <= count - 1'b1;
                CNT_CLR:  count <= '0;
                default:  count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with a per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and counts to reads.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NRD    = 2,
    parameter int CNT_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic                  iss_ready,
    input  logic                  flush,
    output logic                  sb_err
);

    localparam int                NREG      = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] mem [NREG];
    logic [CNT_W-1:0]  cnt [NREG];
    logic [NREG-1:1]   inc_vec;
    logic [NREG-1:1]   dec_vec;
    logic [NREG-1:1]   uf_vec;

    assign iss_ready = (iss_addr == ZERO_ADDR) || (cnt[iss_addr] != CNT_MAX);

    // NOTE: every output of a combinational block gets a default before the loop,
    // so no path leaves a bit unassigned and no latch is inferred.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_vec[r] = iss_valid && iss_ready && (iss_addr == ADDR_W'(r));
            dec_vec[r] = we && (waddr == ADDR_W'(r));
        end
    end

    // Register 0 never has producers in flight, so it gets a constant zero count.
    assign cnt[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc_vec[r]),
            .dec       (dec_vec[r]),
            .clr       (flush),
            .count     (cnt[r]),
            .underflow (uf_vec[r])
        );
    end

    // NOTE: the array is reset explicitly because register contents are
    // architecturally zero after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) mem[r] <= '0;
        end else if (we && (waddr != ZERO_ADDR)) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_err <= 1'b0;
        end else if (|uf_vec) begin
            sb_err <= 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [ADDR_W-1:0] ra;
            ra = raddr[i*ADDR_W +: ADDR_W];
            rdata[i*DATA_W +: DATA_W] = mem[ra];
            rbusy[i] = (cnt[ra] != '0);
            // Forwarded busy mirrors the counter after this cycle's writeback.
            if (BYPASS && we && (ra == waddr) && (ra != ZERO_ADDR)) begin
                rdata[i*DATA_W +: DATA_W] = wdata;
                if (iss_valid && iss_ready && (iss_addr == ra)) begin
                    rbusy[i] = (cnt[ra] != '0);
                end else begin
                    rbusy[i] = (cnt[ra] > CNT_W'(1));
                end
            end
        end
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 32x32 two-read/one-write register file.
- Adds a configurable number of read ports and a per-register pending-write scoreboard, so the ID stage can detect in-flight producers (load-use, multi-cycle ops) without a separate hazard table.
- Sits in the ID stage: read ports are driven by instruction decode, the issue port by the dispatch logic, and the write port by WB.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers.
- NRD, 2, number of independent read ports.
- CNT_W, 2, width of each per-register pending-write counter; CNT_MAX = 2**CNT_W - 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- raddr  in  NRD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rdata  out  NRD*DATA_W  packed read data, same packing as raddr.
- rbusy  out  NRD  1 = addressed register has pending writes (count != 0).
- we  in  1  writeback enable.
- waddr  in  ADDR_W  writeback register address.
- wdata  in  DATA_W  writeback data.
- iss_valid  in  1  dispatch announces a future write to iss_addr.
- iss_addr  in  ADDR_W  destination register of the issued instruction.
- iss_ready  out  1  issue can be accepted this cycle.
- flush  in  1  pipeline flush; clears all pending counts.
- sb_err  out  1  sticky scoreboard underflow flag.

Behaviour:
- Reset (async, rst=1): all registers cleared to 0, all counters cleared to 0, sb_err=0.
  - Consequently rdata is all 0, rbusy all 0 and iss_ready=1.
  - Reset asserted mid-operation discards any same-cycle write or issue.
- Register 0 is hardwired to 0.
  - Writes to it are dropped.
  - Reads of it return 0 with rbusy=0.
  - Issues to it are accepted (iss_ready=1) but never counted.
- Write: on posedge, if we && waddr!=0, reg[waddr] <= wdata. Takes effect on reads in the next cycle (write-then-read, no bypass) unless REGFILE_BYPASS_EN is defined.
- Read: combinational, zero latency. rdata_i = reg[raddr_i]; rbusy_i = (count[raddr_i] != 0).
- iss_ready = (iss_addr == 0) || (count[iss_addr] != CNT_MAX). It is combinational and does not depend on iss_valid.
- Counter update per register r at posedge:
  - inc = iss_valid && iss_ready && iss_addr==r && r!=0.
  - dec = we && waddr==r && r!=0.
  - inc only: +1. dec only: -1. inc and dec together: unchanged.
  - dec when count==0 and no inc: count stays 0, sb_err <= 1.
  - An issue to a full counter (CNT_MAX) is not accepted, because iss_ready=0, even if a dec to the same register occurs that cycle.
- flush=1 at posedge:
  - All counters are cleared to 0 and any same-cycle inc/dec is ignored.
  - The same-cycle register write still happens.
  - No underflow is flagged in a flush cycle.
- sb_err: sticky; cleared only by rst.
- All multi-port reads are fully independent; any ports may alias the same address.

Optional Feature:
- REGFILE_BYPASS_EN defined:
  - If we && waddr==raddr_i && raddr_i!=0, then rdata_i = wdata.
  - rbusy_i reflects the count after the same-cycle dec (i.e. count-1 != 0 when no simultaneous inc to that register).
- Undefined: reads return stored array contents only; rbusy uses the current count.

Decomposition:
- Shared package regfile_pkg:
  - Default DATA_W/ADDR_W constants.
  - REG_ZERO = 0 constant.
  - Counter update-select encoding (CNT_HOLD, CNT_INC, CNT_DEC, CNT_CLR) as a typedef.
- Sub-module sb_counter:
  - One CNT_W-bit up/down counter with clear, hold-on-simultaneous, saturation guard and underflow pulse.
  - Instantiated NREG-1 times via generate; register 0 has none.
  - The underflow pulses are ORed into sb_err.

Test Plan:
- Reset then read all ports at addresses 0, 5 and 31 -> rdata=0, rbusy=0, iss_ready=1, sb_err=0.
- Write 0xDEADBEEF to r5, next cycle read r5 on ports 0 and 1 -> both return 0xDEADBEEF. Write 0x1234 to r0 -> r0 reads 0.
- Issue r7 three times (CNT_W=2), then check -> rbusy=1 on r7 and iss_ready=0 for r7. A fourth issue to r7 with simultaneous we to r7 is not accepted: count 3 -> 2 after writeback, then one more writeback -> 1.
- Simultaneous issue and writeback to r9 at count 1 -> count stays 1 and rbusy stays 1. A writeback to r12 at count 0 -> sb_err=1 and stays 1 until rst.
- Issue r3 twice, then flush with we to r3 of 0xA5A5A5A5 in the same cycle -> count(r3)=0, rbusy=0, r3 reads 0xA5A5A5A5, sb_err=0.
- With REGFILE_BYPASS_EN defined: we to r10 of 0x55 while raddr0=10 and count(r10)=1 -> rdata0=0x55 in the same cycle, rbusy0=0. Without the macro: the same stimulus gives the old value and rbusy0=1.
